// File: rtl/gate_pkg.sv
// Shared constants for the two-beam gate direction decoder.
package gate_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_IN1   = 3'd1;
    localparam logic [2:0] ST_IN2   = 3'd2;
    localparam logic [2:0] ST_IN3   = 3'd3;
    localparam logic [2:0] ST_OUT1  = 3'd4;
    localparam logic [2:0] ST_OUT2  = 3'd5;
    localparam logic [2:0] ST_OUT3  = 3'd6;
    localparam logic [2:0] ST_FAULT = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        IN1   = ST_IN1,
        IN2   = ST_IN2,
        IN3   = ST_IN3,
        OUT1  = ST_OUT1,
        OUT2  = ST_OUT2,
        OUT3  = ST_OUT3,
        FAULT = ST_FAULT
    } state_t;

    localparam logic [1:0] BEAM_CLR = 2'b00;
    localparam logic [1:0] BEAM_A   = 2'b10;
    localparam logic [1:0] BEAM_B   = 2'b01;
    localparam logic [1:0] BEAM_AB  = 2'b11;

    localparam int TIMEOUT_DEFAULT = 200_000_000;

endpackage

// File: rtl/stall_timer.sv
// Stall counter: counts cycles spent in one non-idle state.
module stall_timer #(
    parameter int TIMEOUT_CYCLES = 200_000_000,
    parameter int TW             = 28
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gate_direction_fsm.sv
// Direction decoder for a two-beam gate; emits entry/exit pulses.
module gate_direction_fsm
    import gate_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int TW             = 28
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic car_enter,
    output logic car_exit,
    output logic busy,
    output logic fault
);

    state_t state_q, state_d;
    logic   enter_q, enter_d;
    logic   exit_q, exit_d;
    logic   expired;
    logic   tmr_clr;
    logic   tmr_en;
    logic [1:0] ab;

    assign ab = {a, b};

    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ab == BEAM_A)       state_d = IN1;
                else if (ab == BEAM_B)  state_d = OUT1;
                else if (ab == BEAM_AB) state_d = FAULT;
            end
            IN1: begin
                if (ab == BEAM_AB)       state_d = IN2;
                else if (ab == BEAM_CLR) state_d = IDLE;
                else if (ab == BEAM_B)   state_d = FAULT;
            end
            IN2: begin
                if (ab == BEAM_B)        state_d = IN3;
                else if (ab == BEAM_A)   state_d = IN1;
                else if (ab == BEAM_CLR) state_d = FAULT;
            end
            IN3: begin
                if (ab == BEAM_CLR) begin
                    state_d = IDLE;
                    enter_d = 1'b1;
                end
                else if (ab == BEAM_AB) state_d = IN2;
                else if (ab == BEAM_A)  state_d = FAULT;
            end
            OUT1: begin
                if (ab == BEAM_AB)       state_d = OUT2;
                else if (ab == BEAM_CLR) state_d = IDLE;
                else if (ab == BEAM_A)   state_d = FAULT;
            end
            OUT2: begin
                if (ab == BEAM_A)        state_d = OUT3;
                else if (ab == BEAM_B)   state_d = OUT1;
                else if (ab == BEAM_CLR) state_d = FAULT;
            end
            OUT3: begin
                if (ab == BEAM_CLR) begin
                    state_d = IDLE;
                    exit_d  = 1'b1;
                end
                else if (ab == BEAM_AB) state_d = OUT2;
                else if (ab == BEAM_B)  state_d = FAULT;
            end
            FAULT: begin
                if (ab == BEAM_CLR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A beam-driven move always wins over the stall timeout
        if (expired && state_d == state_q
            && state_q != IDLE && state_q != FAULT)
            state_d = FAULT;
    end

    assign tmr_clr = (state_d != state_q)
                   || (state_q == IDLE) || (state_q == FAULT);
    assign tmr_en  = 1'b1;

    stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TW            (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    assign car_enter = enter_q;
    assign car_exit  = exit_q;
    assign busy      = (state_q != IDLE);
    assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_gate_direction_fsm.sv
// Self-checking bench for gate_direction_fsm.
module tb_gate_direction_fsm;

    localparam int TO = 16;

    typedef struct {
        logic [1:0] ab;
        logic       en;
        logic       ex;
        logic       bz;
        logic       ft;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic a, b;
    logic car_enter, car_exit, busy, fault;

    int tests = 0;
    int fails = 0;

    vec_t vecs[$];

    gate_direction_fsm #(
        .TIMEOUT_CYCLES(TO),
        .TW            (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .car_enter(car_enter),
        .car_exit (car_exit),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [1:0] ab, input logic en,
                       input logic ex, input logic bz, input logic ft);
        vec_t v;
        v.ab = ab; v.en = en; v.ex = ex; v.bz = bz; v.ft = ft;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic en, input logic ex,
                       input logic bz, input logic ft);
        tests++;
        if ({car_enter, car_exit, busy, fault} !== {en, ex, bz, ft}) begin
            fails++;
            $display("FAIL %s: got en/ex/busy/fault=%b%b%b%b want %b%b%b%b",
                     name, car_enter, car_exit, busy, fault, en, ex, bz, ft);
        end
    endtask

    task automatic step(input logic [1:0] ab, input string name,
                        input logic en, input logic ex,
                        input logic bz, input logic ft);
        {a, b} = ab;
        @(posedge clk);
        #1;
        chk(name, en, ex, bz, ft);
    endtask

    initial begin
        reset = 1'b1;
        a = 1'b0;
        b = 1'b0;
        #12;
        chk("reset_state", 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // full entry, each pair held 3 cycles
        for (int i = 0; i < 3; i++) add(2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(2'b10, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(2'b11, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(2'b01, 0, 0, 1, 0);
        add(2'b00, 1, 0, 0, 0);
        add(2'b00, 0, 0, 0, 0);
        add(2'b00, 0, 0, 0, 0);
        // two back-to-back exits
        for (int k = 0; k < 2; k++) begin
            add(2'b01, 0, 0, 1, 0);
            add(2'b11, 0, 0, 1, 0);
            add(2'b10, 0, 0, 1, 0);
            add(2'b00, 0, 1, 0, 0);
        end
        add(2'b00, 0, 0, 0, 0);
        // back-off
        add(2'b10, 0, 0, 1, 0);
        add(2'b11, 0, 0, 1, 0);
        add(2'b10, 0, 0, 1, 0);
        add(2'b00, 0, 0, 0, 0);
        // reversal
        add(2'b10, 0, 0, 1, 0);
        add(2'b11, 0, 0, 1, 0);
        add(2'b01, 0, 0, 1, 0);
        add(2'b11, 0, 0, 1, 0);
        add(2'b10, 0, 0, 1, 0);
        add(2'b00, 0, 0, 0, 0);
        // exit-side back-off
        add(2'b01, 0, 0, 1, 0);
        add(2'b00, 0, 0, 0, 0);
        // illegal 00 -> 11
        add(2'b11, 0, 0, 1, 1);
        add(2'b10, 0, 0, 1, 1);
        add(2'b01, 0, 0, 1, 1);
        add(2'b11, 0, 0, 1, 1);
        add(2'b00, 0, 0, 0, 0);
        add(2'b00, 0, 0, 0, 0);
        // illegal IN1 -> 01
        add(2'b10, 0, 0, 1, 0);
        add(2'b01, 0, 0, 1, 1);
        add(2'b00, 0, 0, 0, 0);
        // illegal OUT2 -> 00
        add(2'b01, 0, 0, 1, 0);
        add(2'b11, 0, 0, 1, 0);
        add(2'b00, 0, 0, 1, 1);
        add(2'b00, 0, 0, 0, 0);

        foreach (vecs[i])
            step(vecs[i].ab, $sformatf("vec%0d", i),
                 vecs[i].en, vecs[i].ex, vecs[i].bz, vecs[i].ft);

        // stall in IN2: fault exactly TO cycles after entering IN2
        step(2'b10, "to_in1", 0, 0, 1, 0);
        step(2'b11, "to_in2", 0, 0, 1, 0);
        for (int k = 1; k <= 20; k++)
            step(2'b11, $sformatf("stall%0d", k), 0, 0, 1, (k >= TO));
        step(2'b01, "stall_01", 0, 0, 1, 1);
        step(2'b00, "stall_00", 0, 0, 0, 0);
        step(2'b00, "stall_idle", 0, 0, 0, 0);

        // async reset while in IN3 with a completing 00 pending
        step(2'b10, "rs_in1", 0, 0, 1, 0);
        step(2'b11, "rs_in2", 0, 0, 1, 0);
        step(2'b01, "rs_in3", 0, 0, 1, 0);
        {a, b} = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        chk("rs_async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rs_held", 0, 0, 0, 0);
        reset = 1'b0;
        step(2'b00, "rs_post0", 0, 0, 0, 0);
        step(2'b00, "rs_post1", 0, 0, 0, 0);
        step(2'b10, "rs_e1", 0, 0, 1, 0);
        step(2'b11, "rs_e2", 0, 0, 1, 0);
        step(2'b01, "rs_e3", 0, 0, 1, 0);
        step(2'b00, "rs_e4", 1, 0, 0, 0);
        step(2'b00, "rs_e5", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
